// File: rtl/regfile_read_stage_pkg.sv
// Shared encodings and widths for the register-read stage.
package regfile_read_stage_pkg;

   // Operand 1 source encodings
   localparam logic [1:0] SRC1_RF    = 2'd0;
   localparam logic [1:0] SRC1_PC    = 2'd1;
   localparam logic [1:0] SRC1_ZERO  = 2'd2;
   localparam logic [1:0] SRC1_CNTID = 2'd3;

   // Operand 2 source encodings
   localparam logic [1:0] SRC2_RF    = 2'd0;
   localparam logic [1:0] SRC2_IMM   = 2'd1;
   localparam logic [1:0] SRC2_CNTL  = 2'd2;
   localparam logic [1:0] SRC2_CNTH  = 2'd3;

   localparam int SEL_W = 2;

   // Field widths of the opaque passthrough bundle, packed MSB-first as
   // {uop, rd, exp, pc_next, badv}. The stage never looks inside it.
   localparam int UOP_W     = 40;
   localparam int RD_W      = 8;
   localparam int EXP_W     = 16;
   localparam int PC_NEXT_W = 32;
   localparam int BADV_W    = 32;
   localparam int PAYLOAD_FIELDS_W = UOP_W + RD_W + EXP_W + PC_NEXT_W + BADV_W;

endpackage

// File: rtl/regfile_bypass_read.sv
// Combinational register read with same-cycle writeback bypass.
// Returns the youngest (highest-index) matching writeback data when any
// enabled port targets the address, else the array data; address 0 is zero.
module regfile_bypass_read #(
   parameter int WB_PORTS = 2,
   parameter int XLEN     = 32,
   parameter int AW       = 5
) (
   input  logic [AW-1:0]            addr,
   input  logic [XLEN-1:0]          arr_data,
   input  logic [WB_PORTS-1:0]      wb_en,
   input  logic [WB_PORTS*AW-1:0]   wb_addr,
   input  logic [WB_PORTS*XLEN-1:0] wb_data,
   output logic [XLEN-1:0]          rd_data,
   output logic                     hit
);

   // Ascending scan so a later (younger) matching port overrides older ones
   always_comb begin
      hit     = 1'b0;
      rd_data = arr_data;
      for (int p = 0; p < WB_PORTS; p++) begin
         if (wb_en[p] && (wb_addr[p*AW +: AW] == addr) && (addr != '0)) begin
            hit     = 1'b1;
            rd_data = wb_data[p*XLEN +: XLEN];
         end
      end
      if (addr == '0) begin
         rd_data = '0;
      end
   end

endmodule

// File: rtl/regfile_read_stage.sv
// Multi-lane register-read stage: architectural register array, writeback
// bypass on capture, and writeback snooping of held operands during stall.
//
// Pipeline contract: the stage has no backpressure output. When stall is low
// every lane's inputs are captured at the edge (one-cycle latency) whether or
// not in_valid is set; when stall is high the output register holds, except
// that a valid lane's RF-sourced operand is refreshed by a matching writeback
// so a stalled instruction never leaves with a stale value. flush beats stall.
module regfile_read_stage
   import regfile_read_stage_pkg::*;
#(
   parameter int LANES     = 2,
   parameter int WB_PORTS  = 2,
   parameter int XLEN      = 32,
   parameter int NREG      = 32,
   parameter int AW        = $clog2(NREG),
   parameter int PAYLOAD_W = 128
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       stall,
   input  logic                       flush,
   input  logic [WB_PORTS-1:0]        wb_en,
   input  logic [WB_PORTS*AW-1:0]     wb_addr,
   input  logic [WB_PORTS*XLEN-1:0]   wb_data,
   input  logic [31:0]                counter_id,
   input  logic [63:0]                stable_counter,
   input  logic [LANES-1:0]           in_valid,
   input  logic [LANES*2-1:0]         in_src1_sel,
   input  logic [LANES*2-1:0]         in_src2_sel,
   input  logic [LANES*AW-1:0]        in_rj,
   input  logic [LANES*AW-1:0]        in_rk,
   input  logic [LANES*XLEN-1:0]      in_pc,
   input  logic [LANES*XLEN-1:0]      in_imm,
   input  logic [LANES*PAYLOAD_W-1:0] in_payload,
   output logic [LANES-1:0]           out_valid,
   output logic [LANES*2-1:0]         out_src1_sel,
   output logic [LANES*2-1:0]         out_src2_sel,
   output logic [LANES*AW-1:0]        out_rj,
   output logic [LANES*AW-1:0]        out_rk,
   output logic [LANES*XLEN-1:0]      out_op1,
   output logic [LANES*XLEN-1:0]      out_op2,
   output logic [LANES*XLEN-1:0]      out_pc,
   output logic [LANES*XLEN-1:0]      out_imm,
   output logic [LANES*PAYLOAD_W-1:0] out_payload
);

   // Register array (no reset; entry 0 is never written and never read)
   logic [XLEN-1:0] rf_q [NREG];
   logic [XLEN-1:0] rf_d [NREG];

   // Output stage registers
   logic [LANES-1:0]           valid_q,    valid_d;
   logic [LANES*2-1:0]         src1_sel_q, src1_sel_d;
   logic [LANES*2-1:0]         src2_sel_q, src2_sel_d;
   logic [LANES*AW-1:0]        rj_q,       rj_d;
   logic [LANES*AW-1:0]        rk_q,       rk_d;
   logic [LANES*XLEN-1:0]      op1_q,      op1_d;
   logic [LANES*XLEN-1:0]      op2_q,      op2_d;
   logic [LANES*XLEN-1:0]      pc_q,       pc_d;
   logic [LANES*XLEN-1:0]      imm_q,      imm_d;
   logic [LANES*PAYLOAD_W-1:0] payload_q,  payload_d;

   // Bypassed reads for capture and snoop
   logic [LANES*XLEN-1:0] cap1_data, cap2_data, snp1_data, snp2_data;
   logic [LANES-1:0]      cap1_hit,  cap2_hit,  snp1_hit,  snp2_hit;
   logic [LANES*XLEN-1:0] cap_op1,   cap_op2;

   // Capture only needs the bypassed value, not whether it came from a port
   logic unused_cap_hit;
   assign unused_cap_hit = ^{cap1_hit, cap2_hit};

   // Per-lane bypass readers: two for incoming operands, two for held operands
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      regfile_bypass_read #(.WB_PORTS(WB_PORTS), .XLEN(XLEN), .AW(AW)) u_cap1 (
         .addr     (in_rj[l*AW +: AW]),
         .arr_data (rf_q[in_rj[l*AW +: AW]]),
         .wb_en    (wb_en),
         .wb_addr  (wb_addr),
         .wb_data  (wb_data),
         .rd_data  (cap1_data[l*XLEN +: XLEN]),
         .hit      (cap1_hit[l])
      );
      regfile_bypass_read #(.WB_PORTS(WB_PORTS), .XLEN(XLEN), .AW(AW)) u_cap2 (
         .addr     (in_rk[l*AW +: AW]),
         .arr_data (rf_q[in_rk[l*AW +: AW]]),
         .wb_en    (wb_en),
         .wb_addr  (wb_addr),
         .wb_data  (wb_data),
         .rd_data  (cap2_data[l*XLEN +: XLEN]),
         .hit      (cap2_hit[l])
      );
      regfile_bypass_read #(.WB_PORTS(WB_PORTS), .XLEN(XLEN), .AW(AW)) u_snp1 (
         .addr     (rj_q[l*AW +: AW]),
         .arr_data (op1_q[l*XLEN +: XLEN]),
         .wb_en    (wb_en),
         .wb_addr  (wb_addr),
         .wb_data  (wb_data),
         .rd_data  (snp1_data[l*XLEN +: XLEN]),
         .hit      (snp1_hit[l])
      );
      regfile_bypass_read #(.WB_PORTS(WB_PORTS), .XLEN(XLEN), .AW(AW)) u_snp2 (
         .addr     (rk_q[l*AW +: AW]),
         .arr_data (op2_q[l*XLEN +: XLEN]),
         .wb_en    (wb_en),
         .wb_addr  (wb_addr),
         .wb_data  (wb_data),
         .rd_data  (snp2_data[l*XLEN +: XLEN]),
         .hit      (snp2_hit[l])
      );
   end

   // Array update: ascending port order so the youngest port wins a collision
   always_comb begin
      rf_d = rf_q;
      for (int p = 0; p < WB_PORTS; p++) begin
         if (wb_en[p] && (wb_addr[p*AW +: AW] != '0)) begin
            rf_d[wb_addr[p*AW +: AW]] = wb_data[p*XLEN +: XLEN];
         end
      end
   end

   // Array storage
   always_ff @(posedge clk) begin
      rf_q <= rf_d;
   end

   // Operand source muxes for the capture path
   always_comb begin
      cap_op1 = '0;
      cap_op2 = '0;
      for (int l = 0; l < LANES; l++) begin
         case (in_src1_sel[l*2 +: 2])
            SRC1_RF:    cap_op1[l*XLEN +: XLEN] = cap1_data[l*XLEN +: XLEN];
            SRC1_PC:    cap_op1[l*XLEN +: XLEN] = in_pc[l*XLEN +: XLEN];
            SRC1_ZERO:  cap_op1[l*XLEN +: XLEN] = '0;
            SRC1_CNTID: cap_op1[l*XLEN +: XLEN] = XLEN'(counter_id);
         endcase
         case (in_src2_sel[l*2 +: 2])
            SRC2_RF:    cap_op2[l*XLEN +: XLEN] = cap2_data[l*XLEN +: XLEN];
            SRC2_IMM:   cap_op2[l*XLEN +: XLEN] = in_imm[l*XLEN +: XLEN];
            SRC2_CNTL:  cap_op2[l*XLEN +: XLEN] = XLEN'(stable_counter[31:0]);
            SRC2_CNTH:  cap_op2[l*XLEN +: XLEN] = XLEN'(stable_counter[63:32]);
         endcase
      end
   end

   // Next output stage: flush clears, no-stall captures, stall holds and snoops
   always_comb begin
      valid_d    = valid_q;
      src1_sel_d = src1_sel_q;
      src2_sel_d = src2_sel_q;
      rj_d       = rj_q;
      rk_d       = rk_q;
      op1_d      = op1_q;
      op2_d      = op2_q;
      pc_d       = pc_q;
      imm_d      = imm_q;
      payload_d  = payload_q;
      if (flush) begin
         valid_d    = '0;
         src1_sel_d = '0;
         src2_sel_d = '0;
         rj_d       = '0;
         rk_d       = '0;
         op1_d      = '0;
         op2_d      = '0;
         pc_d       = '0;
         imm_d      = '0;
         payload_d  = '0;
      end else if (!stall) begin
         valid_d    = in_valid;
         src1_sel_d = in_src1_sel;
         src2_sel_d = in_src2_sel;
         rj_d       = in_rj;
         rk_d       = in_rk;
         op1_d      = cap_op1;
         op2_d      = cap_op2;
         pc_d       = in_pc;
         imm_d      = in_imm;
         payload_d  = in_payload;
      end else begin
         // Snoop hit already excludes r0; counter/PC/IMM operands never refresh
         for (int l = 0; l < LANES; l++) begin
            if (valid_q[l] && (src1_sel_q[l*2 +: 2] == SRC1_RF) && snp1_hit[l]) begin
               op1_d[l*XLEN +: XLEN] = snp1_data[l*XLEN +: XLEN];
            end
            if (valid_q[l] && (src2_sel_q[l*2 +: 2] == SRC2_RF) && snp2_hit[l]) begin
               op2_d[l*XLEN +: XLEN] = snp2_data[l*XLEN +: XLEN];
            end
         end
      end
   end

   // Output stage registers with asynchronous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q    <= '0;
         src1_sel_q <= '0;
         src2_sel_q <= '0;
         rj_q       <= '0;
         rk_q       <= '0;
         op1_q      <= '0;
         op2_q      <= '0;
         pc_q       <= '0;
         imm_q      <= '0;
         payload_q  <= '0;
      end else begin
         valid_q    <= valid_d;
         src1_sel_q <= src1_sel_d;
         src2_sel_q <= src2_sel_d;
         rj_q       <= rj_d;
         rk_q       <= rk_d;
         op1_q      <= op1_d;
         op2_q      <= op2_d;
         pc_q       <= pc_d;
         imm_q      <= imm_d;
         payload_q  <= payload_d;
      end
   end

   assign out_valid    = valid_q;
   assign out_src1_sel = src1_sel_q;
   assign out_src2_sel = src2_sel_q;
   assign out_rj       = rj_q;
   assign out_rk       = rk_q;
   assign out_op1      = op1_q;
   assign out_op2      = op2_q;
   assign out_pc       = pc_q;
   assign out_imm      = imm_q;
   assign out_payload  = payload_q;

endmodule

// File: tb/tb_regfile_read_stage.sv
// Bench for regfile_read_stage: directed mux table, hand sequences for
// bypass/snoop/flush/reset corners, then randomized traffic against a model.
module tb_regfile_read_stage;
   import regfile_read_stage_pkg::*;

   localparam int L  = 2;
   localparam int WB = 2;
   localparam int XL = 32;
   localparam int NR = 32;
   localparam int AW = 5;
   localparam int PW = 128;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic                stall, flush;
   logic [WB-1:0]       wb_en;
   logic [WB*AW-1:0]    wb_addr;
   logic [WB*XL-1:0]    wb_data;
   logic [31:0]         counter_id;
   logic [63:0]         stable_counter;
   logic [L-1:0]        in_valid;
   logic [L*2-1:0]      in_src1_sel, in_src2_sel;
   logic [L*AW-1:0]     in_rj, in_rk;
   logic [L*XL-1:0]     in_pc, in_imm;
   logic [L*PW-1:0]     in_payload;
   logic [L-1:0]        out_valid;
   logic [L*2-1:0]      out_src1_sel, out_src2_sel;
   logic [L*AW-1:0]     out_rj, out_rk;
   logic [L*XL-1:0]     out_op1, out_op2, out_pc, out_imm;
   logic [L*PW-1:0]     out_payload;

   regfile_read_stage #(
      .LANES(L), .WB_PORTS(WB), .XLEN(XL), .NREG(NR), .AW(AW), .PAYLOAD_W(PW)
   ) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .counter_id(counter_id), .stable_counter(stable_counter),
      .in_valid(in_valid), .in_src1_sel(in_src1_sel), .in_src2_sel(in_src2_sel),
      .in_rj(in_rj), .in_rk(in_rk), .in_pc(in_pc), .in_imm(in_imm),
      .in_payload(in_payload),
      .out_valid(out_valid), .out_src1_sel(out_src1_sel), .out_src2_sel(out_src2_sel),
      .out_rj(out_rj), .out_rk(out_rk), .out_op1(out_op1), .out_op2(out_op2),
      .out_pc(out_pc), .out_imm(out_imm), .out_payload(out_payload)
   );

   // ---------------- scoreboard state ----------------
   int tests_run    = 0;
   int tests_failed = 0;
   logic [XL-1:0] exp_q[$];

   // Reference model: architectural registers plus the expected output record
   logic [XL-1:0] rf_m [NR];
   logic          e_valid [L];
   logic [1:0]    e_s1 [L];
   logic [1:0]    e_s2 [L];
   logic [AW-1:0] e_rj [L];
   logic [AW-1:0] e_rk [L];
   logic [XL-1:0] e_op1 [L];
   logic [XL-1:0] e_op2 [L];
   logic [XL-1:0] e_pc [L];
   logic [XL-1:0] e_imm [L];
   logic [PW-1:0] e_pay [L];

   typedef struct {
      logic [1:0]  s1;
      logic [1:0]  s2;
      logic [4:0]  rj;
      logic [4:0]  rk;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [31:0] cid;
      logic [63:0] cnt;
      logic [31:0] x_op1;
      logic [31:0] x_op2;
   } vec_t;
   vec_t vecs [8];

   task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Architectural read as seen by an instruction in this cycle
   function automatic logic [XL-1:0] m_read(input logic [AW-1:0] a);
      if (a == 0) return '0;
      for (int p = WB - 1; p >= 0; p--)
         if (wb_en[p] && wb_addr[p*AW +: AW] == a) return wb_data[p*XL +: XL];
      return rf_m[a];
   endfunction

   function automatic bit m_written(input logic [AW-1:0] a);
      for (int p = 0; p < WB; p++)
         if (wb_en[p] && wb_addr[p*AW +: AW] == a && a != 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      for (int l = 0; l < L; l++) begin
         e_valid[l] = 0; e_s1[l] = 0; e_s2[l] = 0; e_rj[l] = 0; e_rk[l] = 0;
         e_op1[l] = 0; e_op2[l] = 0; e_pc[l] = 0; e_imm[l] = 0; e_pay[l] = 0;
      end
   endtask

   task automatic compare_all();
      for (int l = 0; l < L; l++) begin
         check($sformatf("lane%0d valid", l), PW'(out_valid[l]), PW'(e_valid[l]));
         check($sformatf("lane%0d src1_sel", l), PW'(out_src1_sel[l*2 +: 2]), PW'(e_s1[l]));
         check($sformatf("lane%0d src2_sel", l), PW'(out_src2_sel[l*2 +: 2]), PW'(e_s2[l]));
         check($sformatf("lane%0d rj", l), PW'(out_rj[l*AW +: AW]), PW'(e_rj[l]));
         check($sformatf("lane%0d rk", l), PW'(out_rk[l*AW +: AW]), PW'(e_rk[l]));
         check($sformatf("lane%0d op1", l), PW'(out_op1[l*XL +: XL]), PW'(e_op1[l]));
         check($sformatf("lane%0d op2", l), PW'(out_op2[l*XL +: XL]), PW'(e_op2[l]));
         check($sformatf("lane%0d pc", l), PW'(out_pc[l*XL +: XL]), PW'(e_pc[l]));
         check($sformatf("lane%0d imm", l), PW'(out_imm[l*XL +: XL]), PW'(e_imm[l]));
         check($sformatf("lane%0d payload", l), out_payload[l*PW +: PW], e_pay[l]);
      end
   endtask

   // One clock: predict from the current inputs, clock, then compare everything
   task automatic tick();
      for (int l = 0; l < L; l++) begin
         if (flush) begin
            e_valid[l] = 0; e_s1[l] = 0; e_s2[l] = 0; e_rj[l] = 0; e_rk[l] = 0;
            e_op1[l] = 0; e_op2[l] = 0; e_pc[l] = 0; e_imm[l] = 0; e_pay[l] = 0;
         end else if (!stall) begin
            e_valid[l] = in_valid[l];
            e_s1[l]    = in_src1_sel[l*2 +: 2];
            e_s2[l]    = in_src2_sel[l*2 +: 2];
            e_rj[l]    = in_rj[l*AW +: AW];
            e_rk[l]    = in_rk[l*AW +: AW];
            e_pc[l]    = in_pc[l*XL +: XL];
            e_imm[l]   = in_imm[l*XL +: XL];
            e_pay[l]   = in_payload[l*PW +: PW];
            case (e_s1[l])
               SRC1_RF:   e_op1[l] = m_read(e_rj[l]);
               SRC1_PC:   e_op1[l] = e_pc[l];
               SRC1_ZERO: e_op1[l] = '0;
               default:   e_op1[l] = counter_id;
            endcase
            case (e_s2[l])
               SRC2_RF:   e_op2[l] = m_read(e_rk[l]);
               SRC2_IMM:  e_op2[l] = e_imm[l];
               SRC2_CNTL: e_op2[l] = stable_counter[31:0];
               default:   e_op2[l] = stable_counter[63:32];
            endcase
         end else begin
            if (e_valid[l] && e_s1[l] == SRC1_RF && m_written(e_rj[l])) e_op1[l] = m_read(e_rj[l]);
            if (e_valid[l] && e_s2[l] == SRC2_RF && m_written(e_rk[l])) e_op2[l] = m_read(e_rk[l]);
         end
      end
      for (int p = 0; p < WB; p++)
         if (wb_en[p] && wb_addr[p*AW +: AW] != 0) rf_m[wb_addr[p*AW +: AW]] = wb_data[p*XL +: XL];
      @(posedge clk);
      #1;
      compare_all();
   endtask

   // ---------------- driver tasks ----------------
   task automatic clear_inputs();
      stall = 0; flush = 0; wb_en = '0; wb_addr = '0; wb_data = '0;
      counter_id = '0; stable_counter = '0;
      in_valid = '0; in_src1_sel = '0; in_src2_sel = '0; in_rj = '0; in_rk = '0;
      in_pc = '0; in_imm = '0; in_payload = '0;
   endtask

   task automatic set_wb(input int p, input logic en, input logic [AW-1:0] a, input logic [XL-1:0] d);
      wb_en[p] = en;
      wb_addr[p*AW +: AW] = a;
      wb_data[p*XL +: XL] = d;
   endtask

   task automatic set_lane(input int l, input logic v, input logic [1:0] s1, input logic [1:0] s2,
                           input logic [AW-1:0] rj, input logic [AW-1:0] rk,
                           input logic [XL-1:0] pc, input logic [XL-1:0] imm);
      in_valid[l] = v;
      in_src1_sel[l*2 +: 2] = s1;
      in_src2_sel[l*2 +: 2] = s2;
      in_rj[l*AW +: AW] = rj;
      in_rk[l*AW +: AW] = rk;
      in_pc[l*XL +: XL] = pc;
      in_imm[l*XL +: XL] = imm;
      in_payload[l*PW +: PW] = {$urandom, $urandom, $urandom, $urandom};
   endtask

   initial begin
      for (int i = 0; i < NR; i++) rf_m[i] = '0;
      model_reset();
      clear_inputs();
      rst = 1'b1;
      #1;
      check("reset out_valid", PW'(out_valid), '0);
      check("reset out_op1", PW'(out_op1), '0);
      check("reset out_payload", out_payload[PW-1:0], '0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;

      // Preload r[i] = 0xA000_0000 | i, two registers per cycle
      for (int i = 1; i < NR; i += 2) begin
         clear_inputs();
         set_wb(0, 1'b1, AW'(i), 32'hA000_0000 | i);
         if (i + 1 < NR) set_wb(1, 1'b1, AW'(i + 1), 32'hA000_0000 | (i + 1));
         tick();
      end

      // Source-select table against the preloaded array
      vecs[0] = '{SRC1_RF,    SRC2_RF,   5'd1,  5'd31, 32'h0,         32'h0,         32'h0,         64'h0,                 32'hA000_0001, 32'hA000_001F};
      vecs[1] = '{SRC1_PC,    SRC2_IMM,  5'd4,  5'd4,  32'h8000_0040, 32'hFFFF_FFFC, 32'h0,         64'h0,                 32'h8000_0040, 32'hFFFF_FFFC};
      vecs[2] = '{SRC1_ZERO,  SRC2_CNTL, 5'd9,  5'd9,  32'h1,         32'h2,         32'h3,         64'h1122_3344_5566_7788, 32'h0,       32'h5566_7788};
      vecs[3] = '{SRC1_CNTID, SRC2_CNTH, 5'd9,  5'd9,  32'h1,         32'h2,         32'hC0DE_0001, 64'h1122_3344_5566_7788, 32'hC0DE_0001, 32'h1122_3344};
      vecs[4] = '{SRC1_RF,    SRC2_RF,   5'd0,  5'd0,  32'h5,         32'h6,         32'h7,         64'h8,                 32'h0,         32'h0};
      vecs[5] = '{SRC1_RF,    SRC2_IMM,  5'd16, 5'd3,  32'h0,         32'h12,        32'h0,         64'h0,                 32'hA000_0010, 32'h0000_0012};
      vecs[6] = '{SRC1_PC,    SRC2_RF,   5'd8,  5'd2,  32'h1C00_0000, 32'h0,         32'h0,         64'h0,                 32'h1C00_0000, 32'hA000_0002};
      vecs[7] = '{SRC1_CNTID, SRC2_CNTL, 5'd0,  5'd0,  32'h0,         32'h0,         32'h0,         64'hFFFF_FFFF_0000_0001, 32'h0,       32'h0000_0001};
      for (int v = 0; v < 8; v++) begin
         clear_inputs();
         counter_id = vecs[v].cid;
         stable_counter = vecs[v].cnt;
         for (int l = 0; l < L; l++)
            set_lane(l, 1'b1, vecs[v].s1, vecs[v].s2, vecs[v].rj, vecs[v].rk, vecs[v].pc, vecs[v].imm);
         tick();
         for (int l = 0; l < L; l++) begin
            check($sformatf("table%0d lane%0d op1", v, l), PW'(out_op1[l*XL +: XL]), PW'(vecs[v].x_op1));
            check($sformatf("table%0d lane%0d op2", v, l), PW'(out_op2[l*XL +: XL]), PW'(vecs[v].x_op2));
         end
      end

      // Write then read next cycle
      clear_inputs();
      set_wb(0, 1'b1, 5'd5, 32'hAAAA);
      tick();
      clear_inputs();
      set_lane(0, 1'b1, SRC1_RF, SRC2_IMM, 5'd5, 5'd0, 32'h0, 32'h0);
      tick();
      check("wr_then_rd op1", PW'(out_op1[31:0]), PW'(32'hAAAA));

      // Same-address collision: younger port wins both bypass and array
      clear_inputs();
      set_wb(0, 1'b1, 5'd7, 32'h1111);
      set_wb(1, 1'b1, 5'd7, 32'h2222);
      set_lane(1, 1'b1, SRC1_ZERO, SRC2_RF, 5'd0, 5'd7, 32'h0, 32'h0);
      tick();
      check("collision bypass op2", PW'(out_op2[63:32]), PW'(32'h2222));
      wb_en = '0;
      tick();
      check("collision array op2", PW'(out_op2[63:32]), PW'(32'h2222));

      // Stall snoop: held r3 operand refreshed by a writeback in stall cycle 2
      clear_inputs();
      set_wb(0, 1'b1, 5'd3, 32'h10);
      tick();
      clear_inputs();
      set_lane(0, 1'b1, SRC1_RF, SRC2_IMM, 5'd3, 5'd0, 32'h0, 32'h0);
      tick();
      check("snoop capture op1", PW'(out_op1[31:0]), PW'(32'h10));
      stall = 1'b1;
      set_lane(0, 1'b1, SRC1_RF, SRC2_IMM, 5'd4, 5'd0, 32'h0, 32'h0);
      exp_q.push_back(32'h10);
      exp_q.push_back(32'h99);
      exp_q.push_back(32'h99);
      for (int c = 0; c < 3; c++) begin
         wb_en = '0;
         if (c == 1) set_wb(1, 1'b1, 5'd3, 32'h99);
         tick();
         check($sformatf("snoop stall%0d op1", c), PW'(out_op1[31:0]), PW'(exp_q.pop_front()));
      end
      clear_inputs();
      set_lane(0, 1'b1, SRC1_RF, SRC2_IMM, 5'd3, 5'd0, 32'h0, 32'h0);
      tick();
      check("snoop array op1", PW'(out_op1[31:0]), PW'(32'h99));

      // r0 stays zero under a write
      clear_inputs();
      set_wb(0, 1'b1, 5'd0, 32'hFFFF);
      set_lane(0, 1'b1, SRC1_RF, SRC2_IMM, 5'd0, 5'd0, 32'h0, 32'h0);
      tick();
      check("r0 bypass op1", PW'(out_op1[31:0]), '0);
      wb_en = '0;
      tick();
      check("r0 array op1", PW'(out_op1[31:0]), '0);

      // Flush beats stall
      clear_inputs();
      for (int l = 0; l < L; l++)
         set_lane(l, 1'b1, SRC1_PC, SRC2_IMM, 5'd1, 5'd2, 32'h1234, 32'h5678);
      tick();
      flush = 1'b1;
      stall = 1'b1;
      tick();
      check("flush out_valid", PW'(out_valid), '0);
      check("flush out_pc", PW'(out_pc), '0);

      // Asynchronous reset in the middle of a stall
      clear_inputs();
      for (int l = 0; l < L; l++)
         set_lane(l, 1'b1, SRC1_RF, SRC2_RF, 5'd9, 5'd10, 32'hCAFE, 32'hBEEF);
      tick();
      stall = 1'b1;
      tick();
      #2;
      rst = 1'b1;
      #1;
      check("async rst out_valid", PW'(out_valid), '0);
      check("async rst out_op1", PW'(out_op1), '0);
      check("async rst out_imm", PW'(out_imm), '0);
      model_reset();
      #2;
      rst = 1'b0;
      @(posedge clk); #1;

      // Counter operand never snooped
      clear_inputs();
      stable_counter = 64'h1234_5678_9ABC_DEF0;
      set_lane(0, 1'b1, SRC1_ZERO, SRC2_CNTH, 5'd0, 5'd9, 32'h0, 32'h0);
      tick();
      check("cnth capture op2", PW'(out_op2[31:0]), PW'(32'h1234_5678));
      stall = 1'b1;
      set_wb(0, 1'b1, 5'd9, 32'hDEAD);
      set_wb(1, 1'b1, 5'd9, 32'hBEEF);
      tick();
      check("cnth stall1 op2", PW'(out_op2[31:0]), PW'(32'h1234_5678));
      stable_counter = 64'h0;
      tick();
      check("cnth stall2 op2", PW'(out_op2[31:0]), PW'(32'h1234_5678));

      // Randomized traffic; small address range raises bypass/snoop collisions
      for (int n = 0; n < 400; n++) begin
         stall = ($urandom_range(0, 9) < 4);
         flush = ($urandom_range(0, 24) == 0);
         counter_id = $urandom;
         stable_counter = {$urandom, $urandom};
         for (int p = 0; p < WB; p++)
            set_wb(p, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom);
         for (int l = 0; l < L; l++)
            set_lane(l, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                     AW'($urandom_range(0, 7)), AW'($urandom_range(0, 31)), $urandom, $urandom);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/regfile_read_stage.md
Name: regfile_read_stage

Overview:
- Parametrised multi-lane register-read pipeline stage for the issue→execute path.
- Holds the architectural integer register array and accepts WB_PORTS writeback ports.
- Serves LANES issue lanes. Each lane gets two operands, selected from RF/PC/IMM/counter sources, with writeback bypass.
- Adds stall-hold operand snooping: a held operand that a writeback overwrites during a stall is refreshed, so stalled instructions never carry stale values.

Parameters:
- LANES, 2, number of issue lanes.
- WB_PORTS, 2, number of writeback ports. Higher index is younger.
- XLEN, 32, data width.
- NREG, 32, number of architectural registers. Register 0 is hardwired to zero.
- AW, $clog2(NREG), register address width.
- PAYLOAD_W, 128, width of the opaque per-lane passthrough bundle (uop, rd, exp, pc_next, badv).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold the output stage.
- flush  in  1  synchronous clear of the output stage.
- wb_en  in  WB_PORTS  writeback enables.
- wb_addr  in  WB_PORTS*AW  writeback addresses.
- wb_data  in  WB_PORTS*XLEN  writeback data.
- counter_id  in  32  counter ID source.
- stable_counter  in  64  stable counter source.
- in_valid  in  LANES  lane valid.
- in_src1_sel  in  LANES*2  0=RF, 1=PC, 2=ZERO, 3=CNTID.
- in_src2_sel  in  LANES*2  0=RF, 1=IMM, 2=CNTL, 3=CNTH.
- in_rj, in_rk  in  LANES*AW  source register addresses.
- in_pc, in_imm  in  LANES*XLEN  lane PC and immediate.
- in_payload  in  LANES*PAYLOAD_W  passthrough bundle.
- out_valid  out  LANES  registered lane valid.
- out_src1_sel, out_src2_sel  out  LANES*2  registered source selects.
- out_rj, out_rk  out  LANES*AW  registered source addresses.
- out_op1, out_op2  out  LANES*XLEN  registered operands.
- out_pc, out_imm  out  LANES*XLEN  registered PC and immediate.
- out_payload  out  LANES*PAYLOAD_W  registered passthrough bundle.

Behaviour:
- Register array
  - Not reset.
  - Register 0 always reads 0. Writes to address 0 are discarded.
- Writes
  - Every rising clk edge, each port with wb_en set writes wb_data to wb_addr.
  - If several enabled ports target the same address, the highest-index port wins.
  - Writes are unaffected by stall, flush, or lane valid.
- Read value for address a
  - If a==0: 0.
  - Else, if any enabled port has wb_addr==a: data of the highest-index such port (same-cycle bypass).
  - Else: array[a].
- Operand sourcing
  - op1: RF gives read(rj); PC gives in_pc; ZERO gives 0; CNTID gives counter_id.
  - op2: RF gives read(rk); IMM gives in_imm; CNTL gives stable_counter[31:0]; CNTH gives stable_counter[63:32].
  - Every lane uses the selects, with no ALU-type special case.
- Reset
  - While rst is high, all out_* are 0, asynchronously.
- Pipeline priority at each edge: flush > stall > capture.
  - flush: all out_* are set to 0.
  - capture (stall low): all in_* are registered. Latency is 1 cycle.
  - stall: all outputs hold, with the snoop exception below.
- Snoop during stall, per lane and per operand
  - Condition: out_valid=1, the operand's registered select is RF, its registered address is non-zero, and some enabled wb port matches that address.
  - Action: the operand is replaced by the highest-index matching wb_data.
  - Counter and CNTID operands are never refreshed.
- Invalid lanes
  - Data is still captured but is don't-care downstream. Snoop is suppressed.
- Lanes are independent. One lane reading a register that another lane's instruction writes in the same cycle is the issue stage's problem, not handled here.

Decomposition:
- Shared package
  - SRC1_RF/PC/ZERO/CNTID and SRC2_RF/IMM/CNTL/CNTH localparam encodings.
  - Width constants for the passthrough payload fields.
- Sub-module regfile_bypass_read
  - Combinational.
  - Given an address, the array read data and all wb ports, returns the priority-bypassed value.
  - Also returns a hit flag, reused by both the capture path and the snoop path.
  - Instantiated 2*LANES times for capture and 2*LANES times for snoop.

Test Plan:
1. Write r5=0xAAAA via port0, then next cycle issue lane0 with rj=5, src1=RF → out_op1=0xAAAA after 1 cycle.
2. Same cycle: port0 writes r7=0x1111, port1 writes r7=0x2222, lane1 reads rk=7 with src2=RF → out_op2=0x2222, and the array holds 0x2222.
3. Lane0 captures rj=3 (value 0x10), stall held 3 cycles, port1 writes r3=0x99 in cycle 2 → out_op1 becomes 0x99 the following cycle and stays until stall drops.
4. Write r0=0xFFFF while reading rj=0 → out_op1=0, and a later read of r0 is still 0.
5. Assert flush and stall together with valid inputs → all out_* are 0 next cycle. Assert rst mid-stall → outputs are 0 immediately, without waiting for a clock edge.
6. src2=CNTH with stable_counter=0x1234_5678_9ABC_DEF0, then stall with wb writes to rk → out_op2=0x12345678 and stays unchanged.
